orv64_icache_sysbus_refill: RTL

Parametrised I-cache line-refill engine between the ORV64 I-cache miss path and the sysbus read channel. Generalises the single-outstanding, fixed-order refill to configurable line/beat sizes, up to MAX_OUTST pipelined single-beat reads, and critical-beat-first ordering. Responses are placed by ID, so they may return in any order. Adds error reporting, flush/abort with drain, and a resp_valid/resp_ready handshake to the cache.

---
 rtl/orv64_icache_sysbus_refill.sv | 138 +++++++++++++
 1 files changed

// File: rtl/orv64_icache_sysbus_refill.sv
// I-cache line-refill engine: issues up to MAX_OUTST single-beat sysbus reads,
// critical beat first, places responses by ID and hands the full line to the cache.
module orv64_icache_sysbus_refill #(
  parameter int LINE_BYTES = 32,
  parameter int BEAT_BYTES = 8,
  parameter int PADDR_W    = 56,
  parameter int ID_W       = 4,
  parameter int MAX_OUTST  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [PADDR_W-1:0]        req_paddr,
  input  logic                      flush,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [LINE_BYTES*8-1:0]   resp_line,
  output logic                      resp_err,
  output logic                      sysbus_req_if_arvalid,
  input  logic                      sysbus_req_if_arready,
  output logic [PADDR_W-1:0]        sysbus_req_if_araddr,
  output logic [ID_W-1:0]           sysbus_req_if_arid,
  input  logic                      sysbus_resp_if_rvalid,
  output logic                      sysbus_resp_if_rready,
  input  logic [BEAT_BYTES*8-1:0]   sysbus_resp_if_rdata,
  input  logic [ID_W-1:0]           sysbus_resp_if_rid,
  input  logic [1:0]                sysbus_resp_if_rresp
);

  localparam int NUM_BEATS = LINE_BYTES / BEAT_BYTES;
  localparam int BI_W      = $clog2(NUM_BEATS);
  localparam int GEN_W     = ID_W - BI_W;
  localparam int BO_W      = $clog2(BEAT_BYTES);
  localparam int LO_W      = $clog2(LINE_BYTES);
  localparam int CNT_W     = BI_W + 1;
  localparam int BEAT_W    = BEAT_BYTES * 8;
  localparam logic [CNT_W-1:0] NB = CNT_W'(NUM_BEATS);
  localparam logic [CNT_W-1:0] MO = CNT_W'(MAX_OUTST);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

  state_t                   state, state_nxt;
  logic [PADDR_W-LO_W-1:0]  line_addr;
  logic [BI_W-1:0]          crit, beat;
  logic [CNT_W-1:0]         issued, recvd, recvd_nxt;
  logic [GEN_W-1:0]         gen;
  logic                     err;
  logic                     ar_fire, r_hit;
  logic [BEAT_W-1:0]        slots [NUM_BEATS];
  logic                     unused_bits;

  assign unused_bits = ^req_paddr[BO_W-1:0];

  assign beat      = crit + issued[BI_W-1:0];
  assign ar_fire   = sysbus_req_if_arvalid && sysbus_req_if_arready;
  // Beats tagged with an older generation belong to an aborted refill.
  assign r_hit     = sysbus_resp_if_rvalid && sysbus_resp_if_rready &&
                     (sysbus_resp_if_rid[ID_W-1:BI_W] == gen);
  assign recvd_nxt = recvd + {{BI_W{1'b0}}, r_hit};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so every path drives the signal and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_valid) state_nxt = BUSY;
      BUSY:  if (flush)     state_nxt = (recvd_nxt == issued) ? IDLE : DRAIN;
             else if (recvd_nxt == NB) state_nxt = DONE;
      DONE:  if (resp_ready) state_nxt = IDLE;
      DRAIN: if (recvd_nxt == issued) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready             = 1'b0;
    sysbus_req_if_arvalid = 1'b0;
    sysbus_resp_if_rready = 1'b0;
    resp_valid            = 1'b0;
    resp_err              = 1'b0;
    case (state)
      IDLE:  req_ready = 1'b1;
      BUSY: begin
        sysbus_req_if_arvalid = (issued < NB) && ((issued - recvd) < MO) && !flush;
        sysbus_resp_if_rready = 1'b1;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_err   = err;
      end
      DRAIN: sysbus_resp_if_rready = 1'b1;
      default: ;
    endcase
  end

  assign sysbus_req_if_araddr = {line_addr, beat, {BO_W{1'b0}}};
  assign sysbus_req_if_arid   = {gen, beat};

  always_comb begin
    resp_line = '0;
    if (state == DONE)
      for (int i = 0; i < NUM_BEATS; i++) resp_line[i*BEAT_W +: BEAT_W] = slots[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_addr <= '0;
      crit      <= '0;
      issued    <= '0;
      recvd     <= '0;
      gen       <= '0;
      err       <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      line_addr <= req_paddr[PADDR_W-1:LO_W];
      crit      <= req_paddr[LO_W-1:BO_W];
      issued    <= '0;
      recvd     <= '0;
      err       <= 1'b0;
      gen       <= gen + 1'b1;
    end else begin
      if (ar_fire) issued <= issued + 1'b1;
      if (r_hit)   recvd  <= recvd_nxt;
      if (r_hit && state == BUSY && sysbus_resp_if_rresp != 2'b00) err <= 1'b1;
    end
  end

  // NOTE: line storage has no reset; every slot is rewritten before DONE exposes it.
  always_ff @(posedge clk) begin
    if (state == BUSY && r_hit) slots[sysbus_resp_if_rid[BI_W-1:0]] <= sysbus_resp_if_rdata;
  end

endmodule
